crt_timing_generator: RTL and testbench



---
 rtl/crt_timing_pkg.sv | 26 ++
 rtl/crt_pixel_tick.sv | 35 +++
 rtl/crt_timing_generator.sv | 138 +++++++++++++
 tb/tb_crt_timing_generator.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/crt_timing_pkg.sv
// Shared CRT timing constants: 640x480@60 defaults, a small simulation profile, sync polarities.
package crt_timing_pkg;

  localparam int DEF_X   = 640;
  localparam int DEF_HFP = 16;
  localparam int DEF_HSP = 96;
  localparam int DEF_HBP = 48;
  localparam int DEF_Y   = 480;
  localparam int DEF_VFP = 10;
  localparam int DEF_VSP = 2;
  localparam int DEF_VBP = 33;

  // Reduced profile: 12 clocks per line, 10 lines per frame.
  localparam int SIM_X   = 8;
  localparam int SIM_HFP = 1;
  localparam int SIM_HSP = 2;
  localparam int SIM_HBP = 1;
  localparam int SIM_Y   = 4;
  localparam int SIM_VFP = 2;
  localparam int SIM_VSP = 1;
  localparam int SIM_VBP = 3;

  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

endpackage

// File: rtl/crt_pixel_tick.sv
// Fractional divider: phase accumulator producing a one-clock pixel enable at CRT/System rate.
module crt_pixel_tick #(
  parameter int SystemClockSize = 10
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic [SystemClockSize-1:0] SystemClockFreq,
  input  logic [SystemClockSize-1:0] CRTClockFreq,
  output logic                       tick_o
);

  localparam int AW = SystemClockSize + 1;

  logic [AW-1:0] acc_q, acc_d;
  logic [AW:0]   sum;
  logic [AW:0]   sys_ext;

  assign sys_ext = {2'b00, SystemClockFreq};
  assign sum     = {1'b0, acc_q} + {2'b00, CRTClockFreq};

  // A zero increment never ticks, even if a lowered SystemClockFreq left acc above it.
  always_comb begin
    tick_o = (CRTClockFreq != '0) && (sum >= sys_ext);
    acc_d  = tick_o ? AW'(sum - sys_ext) : AW'(sum);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/crt_timing_generator.sv
// Programmable CRT sync/coordinate generator; timing shadowed and swapped at each frame wrap.
module crt_timing_generator
  import crt_timing_pkg::*;
#(
  parameter int   ResolutionSize  = 10,
  parameter int   SystemClockSize = 10,
  parameter logic HSyncActive     = SYNC_ACTIVE_LOW,
  parameter logic VSyncActive     = SYNC_ACTIVE_LOW,
  parameter int   DefX            = DEF_X,
  parameter int   DefY            = DEF_Y,
  parameter int   DefHFP          = DEF_HFP,
  parameter int   DefHSP          = DEF_HSP,
  parameter int   DefHBP          = DEF_HBP,
  parameter int   DefVFP          = DEF_VFP,
  parameter int   DefVSP          = DEF_VSP,
  parameter int   DefVBP          = DEF_VBP
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic [SystemClockSize-1:0] SystemClockFreq,
  input  logic [SystemClockSize-1:0] CRTClockFreq,
  input  logic [ResolutionSize-1:0]  Xresolution,
  input  logic [ResolutionSize-1:0]  Yresolution,
  input  logic [ResolutionSize-1:0]  hFrontPorch,
  input  logic [ResolutionSize-1:0]  hSynchPulse,
  input  logic [ResolutionSize-1:0]  hBackPorch,
  input  logic [ResolutionSize-1:0]  vFrontPorch,
  input  logic [ResolutionSize-1:0]  vSynchPulse,
  input  logic [ResolutionSize-1:0]  vBackPorch,
  output logic                       hsync,
  output logic                       vsync,
  output logic [ResolutionSize-1:0]  xpos,
  output logic [ResolutionSize-1:0]  ypos,
  output logic                       ActiveVideo,
  output logic                       LineEnd,
  output logic                       FrameEnd,
  output logic                       PixelClock
);

  localparam int RS = ResolutionSize;

  typedef struct packed {
    logic [RS-1:0] x, hfp, hsp, hbp, y, vfp, vsp, vbp;
  } timing_t;

  localparam timing_t DEF_TIMING = '{x: RS'(DefX), hfp: RS'(DefHFP), hsp: RS'(DefHSP),
                                     hbp: RS'(DefHBP), y: RS'(DefY), vfp: RS'(DefVFP),
                                     vsp: RS'(DefVSP), vbp: RS'(DefVBP)};

  timing_t       timing_in, shadow_q, shadow_d;
  logic          tick;
  logic [RS-1:0] x_q, x_d, y_q, y_d;
  logic [RS-1:0] htot, vtot, hs_lo, vs_lo;
  logic          line_end, frame_end, hs_d, vs_d, av_d;
  logic          hs_q, vs_q, av_q, le_q, fe_q, pix_q;

  assign timing_in = '{x: Xresolution, hfp: hFrontPorch, hsp: hSynchPulse, hbp: hBackPorch,
                       y: Yresolution, vfp: vFrontPorch, vsp: vSynchPulse, vbp: vBackPorch};

  crt_pixel_tick #(.SystemClockSize(SystemClockSize)) u_pixel_tick (
    .Clock           (Clock),
    .Reset           (Reset),
    .SystemClockFreq (SystemClockFreq),
    .CRTClockFreq    (CRTClockFreq),
    .tick_o          (tick)
  );

  assign htot  = shadow_q.x + shadow_q.hfp + shadow_q.hsp + shadow_q.hbp;
  assign vtot  = shadow_q.y + shadow_q.vfp + shadow_q.vsp + shadow_q.vbp;
  assign hs_lo = shadow_q.x + shadow_q.hfp;
  assign vs_lo = shadow_q.y + shadow_q.vfp;

  // Wrap on >= so an overflowed or reprogrammed total can never strand the counters.
  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    shadow_d  = shadow_q;
    line_end  = 1'b0;
    frame_end = 1'b0;
    if (tick) begin
      if (x_q >= htot - RS'(1)) begin
        x_d      = '0;
        line_end = 1'b1;
        if (y_q >= vtot - RS'(1)) begin
          y_d       = '0;
          frame_end = 1'b1;
          shadow_d  = timing_in;
        end else begin
          y_d = y_q + RS'(1);
        end
      end else begin
        x_d = x_q + RS'(1);
      end
    end
  end

  always_comb begin
    hs_d = ((x_d >= hs_lo) && (x_d < hs_lo + shadow_q.hsp)) ? HSyncActive : ~HSyncActive;
    vs_d = ((y_d >= vs_lo) && (y_d < vs_lo + shadow_q.vsp)) ? VSyncActive : ~VSyncActive;
    av_d = (x_d < shadow_q.x) && (y_d < shadow_q.y);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      x_q      <= '0;
      y_q      <= '0;
      shadow_q <= DEF_TIMING;
      hs_q     <= ~HSyncActive;
      vs_q     <= ~VSyncActive;
      av_q     <= 1'b0;
      le_q     <= 1'b0;
      fe_q     <= 1'b0;
      pix_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      le_q     <= line_end;
      fe_q     <= frame_end;
      pix_q    <= tick;
      if (tick) begin
        x_q  <= x_d;
        y_q  <= y_d;
        hs_q <= hs_d;
        vs_q <= vs_d;
        av_q <= av_d;
      end
    end
  end

  assign xpos        = x_q;
  assign ypos        = y_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign ActiveVideo = av_q;
  assign LineEnd     = le_q;
  assign FrameEnd    = fe_q;
  assign PixelClock  = pix_q;

endmodule

// File: tb/tb_crt_timing_generator.sv
// Directed bench for crt_timing_generator using the reduced 12x10 timing profile.
module tb_crt_timing_generator;
  import crt_timing_pkg::*;

  localparam int RS = 10;
  localparam int SS = 10;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic [SS-1:0] sys_f, crt_f;
  logic [RS-1:0] xres, yres, hfp, hsp, hbp, vfp, vsp, vbp;

  logic          hs_a, vs_a, av_a, le_a, fe_a, pc_a;
  logic [RS-1:0] x_a, y_a;
  logic          hs_b, vs_b, av_b, le_b, fe_b, pc_b;
  logic [RS-1:0] x_b, y_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 Clock = ~Clock;

  crt_timing_generator #(
    .ResolutionSize(RS), .SystemClockSize(SS),
    .HSyncActive(SYNC_ACTIVE_LOW), .VSyncActive(SYNC_ACTIVE_LOW),
    .DefX(SIM_X), .DefY(SIM_Y), .DefHFP(SIM_HFP), .DefHSP(SIM_HSP), .DefHBP(SIM_HBP),
    .DefVFP(SIM_VFP), .DefVSP(SIM_VSP), .DefVBP(SIM_VBP)
  ) u_dut (
    .Clock(Clock), .Reset(Reset), .SystemClockFreq(sys_f), .CRTClockFreq(crt_f),
    .Xresolution(xres), .Yresolution(yres), .hFrontPorch(hfp), .hSynchPulse(hsp),
    .hBackPorch(hbp), .vFrontPorch(vfp), .vSynchPulse(vsp), .vBackPorch(vbp),
    .hsync(hs_a), .vsync(vs_a), .xpos(x_a), .ypos(y_a), .ActiveVideo(av_a),
    .LineEnd(le_a), .FrameEnd(fe_a), .PixelClock(pc_a)
  );

  crt_timing_generator #(
    .ResolutionSize(RS), .SystemClockSize(SS),
    .HSyncActive(SYNC_ACTIVE_HIGH), .VSyncActive(SYNC_ACTIVE_LOW),
    .DefX(SIM_X), .DefY(SIM_Y), .DefHFP(SIM_HFP), .DefHSP(SIM_HSP), .DefHBP(SIM_HBP),
    .DefVFP(SIM_VFP), .DefVSP(SIM_VSP), .DefVBP(SIM_VBP)
  ) u_dut_hi (
    .Clock(Clock), .Reset(Reset), .SystemClockFreq(sys_f), .CRTClockFreq(crt_f),
    .Xresolution(xres), .Yresolution(yres), .hFrontPorch(hfp), .hSynchPulse(hsp),
    .hBackPorch(hbp), .vFrontPorch(vfp), .vSynchPulse(vsp), .vBackPorch(vbp),
    .hsync(hs_b), .vsync(vs_b), .xpos(x_b), .ypos(y_b), .ActiveVideo(av_b),
    .LineEnd(le_b), .FrameEnd(fe_b), .PixelClock(pc_b)
  );

  typedef struct {
    int cyc;
    int x, y, hs, vs, av, le, fe;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input int c, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, c, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    @(negedge Clock);
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    cyc = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int le_cnt, fe_cnt, pc_cnt, fe_alone;

    //           cyc   x   y hs vs av le fe
    tbl[0]  = '{   1,  1,  0, 1, 1, 1, 0, 0};
    tbl[1]  = '{   7,  7,  0, 1, 1, 1, 0, 0};
    tbl[2]  = '{   8,  8,  0, 1, 1, 0, 0, 0};
    tbl[3]  = '{   9,  9,  0, 0, 1, 0, 0, 0};
    tbl[4]  = '{  10, 10,  0, 0, 1, 0, 0, 0};
    tbl[5]  = '{  11, 11,  0, 1, 1, 0, 0, 0};
    tbl[6]  = '{  12,  0,  1, 1, 1, 1, 1, 0};
    tbl[7]  = '{  48,  0,  4, 1, 1, 0, 1, 0};
    tbl[8]  = '{  72,  0,  6, 1, 0, 0, 1, 0};
    tbl[9]  = '{  83, 11,  6, 1, 0, 0, 0, 0};
    tbl[10] = '{  84,  0,  7, 1, 1, 0, 1, 0};
    tbl[11] = '{ 120,  0,  0, 1, 1, 1, 1, 1};
    tbl[12] = '{ 121,  1,  0, 1, 1, 1, 0, 0};

    xres = RS'(SIM_X); hfp = RS'(SIM_HFP); hsp = RS'(SIM_HSP); hbp = RS'(SIM_HBP);
    yres = RS'(SIM_Y); vfp = RS'(SIM_VFP); vsp = RS'(SIM_VSP); vbp = RS'(SIM_VBP);
    sys_f = SS'(1);
    crt_f = SS'(1);

    // Reset state
    Reset = 1'b0;
    repeat (2) @(negedge Clock);
    chk("rst_x",  0, int'(x_a),  0);
    chk("rst_y",  0, int'(y_a),  0);
    chk("rst_hs", 0, int'(hs_a), 1);
    chk("rst_vs", 0, int'(vs_a), 1);
    chk("rst_av", 0, int'(av_a), 0);
    chk("rst_le", 0, int'(le_a), 0);
    chk("rst_fe", 0, int'(fe_a), 0);
    chk("rst_pc", 0, int'(pc_a), 0);
    chk("rst_hs_hi", 0, int'(hs_b), 0);
    chk("rst_vs_hi", 0, int'(vs_b), 1);
    chk("rst_xy_hi", 0, int'(x_b) + int'(y_b), 0);
    chk("rst_strobes_hi", 0, int'(av_b) + int'(le_b) + int'(fe_b) + int'(pc_b), 0);

    // Table sweep over two frames at 1:1
    Reset = 1'b1;
    cyc = 0;
    le_cnt = 0; fe_cnt = 0; fe_alone = 0;
    for (int k = 0; k < 240; k++) begin
      step();
      le_cnt += int'(le_a);
      fe_cnt += int'(fe_a);
      if (fe_a && !le_a) fe_alone++;
      for (int i = 0; i < 13; i++) begin
        if (tbl[i].cyc == cyc) begin
          chk("tbl_x",  cyc, int'(x_a),  tbl[i].x);
          chk("tbl_y",  cyc, int'(y_a),  tbl[i].y);
          chk("tbl_hs", cyc, int'(hs_a), tbl[i].hs);
          chk("tbl_vs", cyc, int'(vs_a), tbl[i].vs);
          chk("tbl_av", cyc, int'(av_a), tbl[i].av);
          chk("tbl_le", cyc, int'(le_a), tbl[i].le);
          chk("tbl_fe", cyc, int'(fe_a), tbl[i].fe);
          chk("tbl_pc", cyc, int'(pc_a), 1);
          chk("tbl_hs_hi", cyc, int'(hs_b), 1 - tbl[i].hs);
          chk("tbl_x_hi",  cyc, int'(x_b),  tbl[i].x);
        end
      end
    end
    chk("lineend_count",  cyc, le_cnt, 20);
    chk("frameend_count", cyc, fe_cnt, 2);
    chk("frameend_without_lineend", cyc, fe_alone, 0);

    // Divider 4:1, then frozen with CRTClockFreq = 0
    sys_f = SS'(4);
    do_reset();
    pc_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      pc_cnt += int'(pc_a);
      if (cyc == 3) begin
        chk("div_pc_c3", cyc, int'(pc_a), 0);
        chk("div_x_c3",  cyc, int'(x_a),  0);
      end
      if (cyc == 4) begin
        chk("div_pc_c4", cyc, int'(pc_a), 1);
        chk("div_x_c4",  cyc, int'(x_a),  1);
      end
    end
    chk("div_pc_count", cyc, pc_cnt, 4);
    chk("div_x_after16", cyc, int'(x_a), 4);
    crt_f = SS'(0);
    pc_cnt = 0;
    repeat (20) begin
      step();
      pc_cnt += int'(pc_a);
    end
    chk("freeze_pc_count", cyc, pc_cnt, 0);
    chk("freeze_x", cyc, int'(x_a), 4);

    // Mid-frame X change only takes effect after the frame wraps
    sys_f = SS'(1);
    crt_f = SS'(1);
    do_reset();
    while (cyc < 130) begin
      step();
      if (cyc == 30) xres = RS'(6);
      case (cyc)
        108: begin chk("xchg_old_x", cyc, int'(x_a), 0); chk("xchg_old_le", cyc, int'(le_a), 1); end
        117: chk("xchg_old_hs_x9", cyc, int'(hs_a), 0);
        120: begin chk("xchg_fe", cyc, int'(fe_a), 1); chk("xchg_wrap_y", cyc, int'(y_a), 0); end
        127: begin chk("xchg_new_x7", cyc, int'(x_a), 7); chk("xchg_new_hs7", cyc, int'(hs_a), 0); end
        128: chk("xchg_new_hs8", cyc, int'(hs_a), 0);
        129: chk("xchg_new_hs9", cyc, int'(hs_a), 1);
        130: begin chk("xchg_new_wrap_x", cyc, int'(x_a), 0); chk("xchg_new_le", cyc, int'(le_a), 1); end
        default: ;
      endcase
    end

    // Asynchronous reset mid-frame at (5,2)
    xres = RS'(SIM_X);
    do_reset();
    repeat (29) step();
    chk("pre_arst_x", cyc, int'(x_a), 5);
    chk("pre_arst_y", cyc, int'(y_a), 2);
    #1 Reset = 1'b0;
    #1;
    chk("arst_x",  cyc, int'(x_a),  0);
    chk("arst_y",  cyc, int'(y_a),  0);
    chk("arst_hs", cyc, int'(hs_a), 1);
    chk("arst_av", cyc, int'(av_a), 0);
    chk("arst_pc", cyc, int'(pc_a), 0);
    @(negedge Clock);
    Reset = 1'b1;
    cyc = 0;
    step();
    chk("post_arst_x",  cyc, int'(x_a),  1);
    chk("post_arst_y",  cyc, int'(y_a),  0);
    chk("post_arst_av", cyc, int'(av_a), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
